pmips_mem_arbiter: RTL and testbench
====================================

Name: pmips_mem_arbiter

Overview:
- Shares one single-port synchronous 16-bit memory between the PMIPS instruction-fetch port and the data (MEM-stage) port.
- Sequences each access through a small FSM and returns read data with a one-cycle ready pulse.
- Produces the pipeline stall that freezes the PC and IF/ID while either port waits.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 16, byte-address width of both request ports
DATA_W, 16, data width
RD_LAT, 1, cycles from mem_en to valid mem_rdata (legal 1..7)
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced (legal 1..15)

Ports:
clock  in  1  single system clock, all state on posedge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch byte address (PC)
if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
dm_read  in  1  data read request, held until dm_ready
dm_write  in  1  data write request, held until dm_ready
dm_addr  in  ADDR_W  data byte address (ALU result)
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access strobe (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W-1  word address = request addr[ADDR_W-1:1] (registered)
mem_wdata  out  DATA_W  write data (registered)
mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after mem_en
pipe_stall  out  1  (if_req & ~if_ready) | ((dm_read|dm_write) & ~dm_ready)

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; starve_cnt=0; lat_cnt=0. Outputs mem_en, mem_we, if_ready and dm_ready are 0. mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
- Reset mid-transaction abandons it. No ready pulse is issued. Late mem_rdata is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrates on cycle T.
  - Data is pending (dm_read|dm_write) and not (if_req & starve_cnt==STARVE_MAX): grant data.
  - Otherwise, if if_req: grant fetch.
  - Otherwise, stay in IDLE.
- On grant: register mem_en=1, mem_addr, mem_we=(data grant & dm_write), and mem_wdata. Go to ISSUE (cycle T+1).
- dm_read and dm_write both high: treated as a write.
- ISSUE: lasts exactly one cycle, and mem_en is high only here.
  - Write: go to DONE.
  - Read: load lat_cnt=RD_LAT-1 and go to WAIT.
- WAIT: decrement lat_cnt.
  - When lat_cnt==0, capture mem_rdata into the granted port's rdata register and go to DONE.
  - With RD_LAT=1, mem_rdata is sampled in cycle T+2.
- DONE: the granted port's ready is 1 for exactly one cycle, then go to IDLE.
  - Read: ready in cycle T+3 at RD_LAT=1; in general T+2+RD_LAT.
  - Write: ready in cycle T+2.
- Requesters sample ready at the posedge ending DONE and drop or update their request for the following IDLE cycle.
- if_rdata and dm_rdata hold their last captured value outside ready.
- starve_cnt:
  - On a data grant with if_req=1: increment, saturating at STARVE_MAX.
  - On a data grant with if_req=0: cleared.
  - On a fetch grant: cleared.
- Request signals are not sampled outside IDLE. Changing the address while the request is outstanding has no effect on the in-flight access.
- pipe_stall is combinational from registered ready and the request inputs. It is 0 when no request is pending.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with no requests -> all outputs 0, pipe_stall=0, mem_en never asserted.
- Fetch read, RD_LAT=1: if_req=1, if_addr=0x0004, memory word 2 = 0xA5C3.
  - Cycle T+1: mem_en=1, mem_addr=0x0002, mem_we=0.
  - Cycle T+3: if_ready=1, if_rdata=0xA5C3.
  - pipe_stall=1 in T..T+2 and 0 in T+3.
- Data write priority: if_req=1 and dm_write=1 (dm_addr=0x0010, dm_wdata=0x1234) in the same cycle.
  - Data wins: mem_we=1, mem_addr=0x0008, dm_ready at T+2.
  - Fetch is granted in the next IDLE, and the word at 0x0008 reads back 0x1234.
- Starvation, STARVE_MAX=4: hold if_req=1 while issuing back-to-back dm_read.
  - Exactly 4 data grants occur, then a fetch grant, then data again.
  - starve_cnt=0 after the fetch grant.
- Reset mid-read, RD_LAT=3: assert reset=0 during WAIT -> no ready pulse; next cycle state=IDLE and mem_en=0.
- Read+write conflict: dm_read=1 and dm_write=1 with dm_wdata=0xBEEF -> single write with mem_we=1, then dm_ready; no read data captured.

Source files
------------

// File: rtl/pmips_mem_arbiter.sv
// pmips_mem_arbiter
//   Shares one single-port synchronous memory between the PMIPS fetch port
//   and the MEM-stage data port. Data wins arbitration unless fetch has been
//   passed over STARVE_MAX times in a row. Each access walks
//   IDLE -> ISSUE -> (WAIT) -> DONE, and the granted port sees a one-cycle
//   ready pulse in DONE.
//
// Ports
//   clock, reset       : system clock, synchronous active-low reset
//   if_req/if_addr     : fetch request (byte address), held until if_ready
//   if_rdata/if_ready  : fetched word and its completion pulse
//   dm_read/dm_write   : data request (write wins if both), held until dm_ready
//   dm_addr/dm_wdata   : data byte address and store data
//   dm_rdata/dm_ready  : load data and its completion pulse
//   mem_en/mem_we      : registered memory strobe / write enable
//   mem_addr/mem_wdata : registered word address and write data
//   mem_rdata          : memory read data, RD_LAT cycles after mem_en
//   pipe_stall         : freezes PC and IF/ID while either port waits
module pmips_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Which port owns the in-flight access and whether it is a write.
  typedef struct packed {
    logic dm;
    logic wr;
  } grant_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT - 1);

  state_t            state, state_nxt;
  grant_t            grant, grant_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [2:0]        lat_cnt, lat_nxt;
  logic              mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-2:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;
  logic              if_ready_nxt, dm_ready_nxt;
  logic              dm_pend, fetch_forced;

  // Byte-address LSBs are dropped: memory is word addressed.
  logic addr_lsb_unused;
  assign addr_lsb_unused = if_addr[0] ^ dm_addr[0];

  assign dm_pend      = dm_read | dm_write;
  assign fetch_forced = if_req & (starve_cnt == STARVE_LIM);

  // Ready is registered, so the stall drops in the same cycle as the pulse.
  assign pipe_stall = (if_req & ~if_ready) | (dm_pend & ~dm_ready);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    starve_nxt    = starve_cnt;
    lat_nxt       = lat_cnt;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_ready_nxt  = 1'b0;
    dm_ready_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (dm_pend && !fetch_forced) begin
          grant_nxt     = '{dm: 1'b1, wr: dm_write};
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = dm_write;
          mem_addr_nxt  = dm_addr[ADDR_W-1:1];
          mem_wdata_nxt = dm_wdata;
          // Count how often a waiting fetch was passed over.
          if (if_req)
            starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
          else
            starve_nxt = 4'd0;
          state_nxt = ISSUE;
        end else if (if_req) begin
          grant_nxt     = '{dm: 1'b0, wr: 1'b0};
          mem_en_nxt    = 1'b1;
          mem_addr_nxt  = if_addr[ADDR_W-1:1];
          mem_wdata_nxt = dm_wdata;
          starve_nxt    = 4'd0;
          state_nxt     = ISSUE;
        end
      end

      ISSUE: begin
        if (grant.wr) begin
          dm_ready_nxt = 1'b1;
          state_nxt    = DONE;
        end else begin
          lat_nxt   = LAT_LOAD;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (lat_cnt == 3'd0) begin
          if (grant.dm) begin
            dm_rdata_nxt = mem_rdata;
            dm_ready_nxt = 1'b1;
          end else begin
            if_rdata_nxt = mem_rdata;
            if_ready_nxt = 1'b1;
          end
          state_nxt = DONE;
        end else begin
          lat_nxt = lat_cnt - 3'd1;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      starve_cnt <= 4'd0;
      lat_cnt    <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      starve_cnt <= starve_nxt;
      lat_cnt    <= lat_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_rdata   <= dm_rdata_nxt;
      if_ready   <= if_ready_nxt;
      dm_ready   <= dm_ready_nxt;
    end
  end

endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// Bench for pmips_mem_arbiter: u_dut at RD_LAT=1 on a shared memory model,
// u_dut3 at RD_LAT=3 for the latency / mid-read reset scenario.
module tb_pmips_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // RD_LAT=1 instance
  logic reset, if_req, if_ready, dm_read, dm_write, dm_ready;
  logic mem_en, mem_we, pipe_stall;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-2:0] mem_addr;

  // RD_LAT=3 instance
  logic reset3, if_req3, if_ready3, dm_read3, dm_write3, dm_ready3;
  logic mem_en3, mem_we3, pipe_stall3;
  logic [AW-1:0] if_addr3, dm_addr3;
  logic [DW-1:0] if_rdata3, dm_wdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic [AW-2:0] mem_addr3;

  pmips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pipe_stall(pipe_stall));

  pmips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clock(clock), .reset(reset3),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ready(if_ready3),
    .dm_read(dm_read3), .dm_write(dm_write3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_rdata(dm_rdata3), .dm_ready(dm_ready3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .pipe_stall(pipe_stall3));

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: preload port, RD_LAT=1 read register, 3-stage read pipe.
  logic [DW-1:0] mem [0:32767];
  logic          pl_en = 1'b0;
  logic [14:0]   pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] rd1;
  logic [DW-1:0] p3 [0:2];

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) rd1 <= mem[mem_addr];
    if (mem_en3 && !mem_we3) p3[0] <= mem[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata  = rd1;
  assign mem_rdata3 = p3[2];

  // Scoreboards and grant log
  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_dm[$];
  logic [DW-1:0] exp_dm3[$];
  logic [AW-2:0] grant_log[$];

  always @(negedge clock) if (mem_en) grant_log.push_back(mem_addr);

  task automatic preload(input logic [14:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic wait_if_ready(input int budget, output int cyc);
    cyc = 0;
    while (!if_ready && cyc < budget) begin @(negedge clock); cyc++; end
  endtask

  task automatic wait_dm_ready(input int budget, output int cyc);
    cyc = 0;
    while (!dm_ready && cyc < budget) begin @(negedge clock); cyc++; end
  endtask

  task automatic wait_dm3_ready(input int budget, output int cyc);
    cyc = 0;
    while (!dm_ready3 && cyc < budget) begin @(negedge clock); cyc++; end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({mem_en, mem_we, if_ready, dm_ready, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got en=%b we=%b ifr=%b dmr=%b addr=%h wd=%h ifd=%h dmd=%h want all 0",
                         mem_en, mem_we, if_ready, dm_ready, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    n_tests++;
    if ({mem_en3, dm_ready3, if_ready3, dm_rdata3, if_rdata3, mem_wdata3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs3: got en=%b dmr=%b ifr=%b dmd=%h ifd=%h wd=%h want all 0",
                         mem_en3, dm_ready3, if_ready3, dm_rdata3, if_rdata3, mem_wdata3);
    end
    reset = 1'b1; reset3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_tests++;
      if ({mem_en, pipe_stall, if_ready, dm_ready} !== 4'b0) begin
        n_fail++; $display("FAIL idle_quiet cyc%0d: got en=%b stall=%b ifr=%b dmr=%b want 0", i, mem_en, pipe_stall, if_ready, dm_ready);
      end
    end
  endtask

  task automatic test_fetch_read;
    logic [DW-1:0] want;
    @(negedge clock);                           // T
    if_req = 1'b1; if_addr = 16'h0004; exp_if.push_back(16'hA5C3);
    #1;
    n_tests++;
    if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_T: got %b want 1", pipe_stall); end
    @(negedge clock);                           // T+1
    n_tests++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'h0002}) begin
      n_fail++; $display("FAIL fetch_issue: got en=%b we=%b addr=%h want en=1 we=0 addr=0002", mem_en, mem_we, mem_addr);
    end
    @(negedge clock);                           // T+2
    n_tests++;
    if ({if_ready, pipe_stall} !== 2'b01) begin
      n_fail++; $display("FAIL fetch_wait: got ready=%b stall=%b want ready=0 stall=1", if_ready, pipe_stall);
    end
    @(negedge clock);                           // T+3
    want = exp_if.pop_front();
    n_tests++;
    if ({if_ready, pipe_stall, if_rdata} !== {1'b1, 1'b0, want}) begin
      n_fail++; $display("FAIL fetch_done: got ready=%b stall=%b data=%h want ready=1 stall=0 data=%h", if_ready, pipe_stall, if_rdata, want);
    end
    if_req = 1'b0;
    @(negedge clock);                           // IDLE
    n_tests++;
    if ({if_ready, if_rdata} !== {1'b0, want}) begin
      n_fail++; $display("FAIL fetch_hold: got ready=%b data=%h want ready=0 data=%h", if_ready, if_rdata, want);
    end
  endtask

  task automatic test_write_priority;
    logic [DW-1:0] want;
    int cyc;
    @(negedge clock);                           // T
    if_req = 1'b1; if_addr = 16'h0010;
    dm_write = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'h1234;
    exp_if.push_back(16'h1234);
    @(negedge clock);                           // T+1
    n_tests++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 15'h0008, 16'h1234}) begin
      n_fail++; $display("FAIL prio_issue: got en=%b we=%b addr=%h wd=%h want 1 1 0008 1234", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_tests++;
    if (u_dut.starve_cnt !== 4'd1) begin n_fail++; $display("FAIL prio_starve_inc: got %0d want 1", u_dut.starve_cnt); end
    @(negedge clock);                           // T+2
    n_tests++;
    if ({dm_ready, if_ready} !== 2'b10) begin
      n_fail++; $display("FAIL prio_dm_ready: got dm=%b if=%b want dm=1 if=0", dm_ready, if_ready);
    end
    dm_write = 1'b0;
    @(negedge clock);                           // T+3 IDLE
    @(negedge clock);                           // T+4 fetch ISSUE
    n_tests++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 15'h0008}) begin
      n_fail++; $display("FAIL prio_fetch_issue: got en=%b we=%b addr=%h want 1 0 0008", mem_en, mem_we, mem_addr);
    end
    n_tests++;
    if (u_dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL prio_starve_clr: got %0d want 0", u_dut.starve_cnt); end
    wait_if_ready(10, cyc);
    want = exp_if.pop_front();
    n_tests++;
    if ({if_ready, if_rdata} !== {1'b1, want} || cyc != 2) begin
      n_fail++; $display("FAIL prio_readback: got ready=%b data=%h after %0d want ready=1 data=%h after 2", if_ready, if_rdata, cyc, want);
    end
    if_req = 1'b0;
  endtask

  task automatic test_starvation;
    logic [DW-1:0] want;
    logic [AW-2:0] exp_log [7];
    int di, cyc;
    bit fetch_done;
    exp_log[0] = 15'h100; exp_log[1] = 15'h101; exp_log[2] = 15'h102; exp_log[3] = 15'h103;
    exp_log[4] = 15'h080; exp_log[5] = 15'h104; exp_log[6] = 15'h105;
    @(negedge clock);
    grant_log.delete();
    if_req = 1'b1; if_addr = 16'h0100; exp_if.push_back(16'hF00D);
    di = 0; dm_read = 1'b1; dm_addr = 16'h0200; exp_dm.push_back(16'h5000);
    fetch_done = 0; cyc = 0;
    while (di < 6 && cyc < 200) begin
      @(negedge clock); cyc++;
      if (mem_en && mem_addr == 15'h103) begin
        n_tests++;
        if (u_dut.starve_cnt !== 4'd4) begin n_fail++; $display("FAIL starve_at_max: got %0d want 4", u_dut.starve_cnt); end
      end
      if (mem_en && mem_addr == 15'h080) begin
        n_tests++;
        if (u_dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_after_fetch: got %0d want 0", u_dut.starve_cnt); end
      end
      if (dm_ready) begin
        want = exp_dm.pop_front();
        n_tests++;
        if (dm_rdata !== want) begin n_fail++; $display("FAIL starve_dm_data%0d: got %h want %h", di, dm_rdata, want); end
        di++;
        if (di < 6) begin
          dm_addr = 16'h0200 + 16'(2 * di);
          exp_dm.push_back(16'h5000 + 16'(di));
        end else dm_read = 1'b0;
      end
      if (if_ready) begin
        want = exp_if.pop_front();
        n_tests++;
        if (if_rdata !== want) begin n_fail++; $display("FAIL starve_if_data: got %h want %h", if_rdata, want); end
        if_req = 1'b0; fetch_done = 1;
      end
    end
    dm_read = 1'b0; if_req = 1'b0;
    n_tests++;
    if (di != 6 || !fetch_done) begin n_fail++; $display("FAIL starve_progress: got %0d reads fetch=%0d want 6 reads fetch=1", di, fetch_done); end
    n_tests++;
    if (grant_log.size() != 7) begin n_fail++; $display("FAIL starve_grant_count: got %0d want 7", grant_log.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (grant_log[i] !== exp_log[i]) begin n_fail++; $display("FAIL starve_grant%0d: got %h want %h", i, grant_log[i], exp_log[i]); end
      end
    end
  endtask

  task automatic test_rw_conflict;
    logic [DW-1:0] want;
    int cyc;
    @(negedge clock);                           // T
    grant_log.delete();
    dm_read = 1'b1; dm_write = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'hBEEF;
    @(negedge clock);                           // T+1
    n_tests++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 15'h0010, 16'hBEEF}) begin
      n_fail++; $display("FAIL rw_issue: got en=%b we=%b addr=%h wd=%h want 1 1 0010 beef", mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clock);                           // T+2
    n_tests++;
    if ({dm_ready, dm_rdata} !== {1'b1, 16'h5005}) begin
      n_fail++; $display("FAIL rw_done: got ready=%b data=%h want ready=1 data=5005 (unchanged)", dm_ready, dm_rdata);
    end
    dm_write = 1'b0; dm_read = 1'b0;
    @(negedge clock);                           // IDLE: read it back
    dm_read = 1'b1; exp_dm.push_back(16'hBEEF);
    @(negedge clock);
    wait_dm_ready(10, cyc);
    want = exp_dm.pop_front();
    n_tests++;
    if ({dm_ready, dm_rdata} !== {1'b1, want}) begin
      n_fail++; $display("FAIL rw_readback: got ready=%b data=%h want ready=1 data=%h", dm_ready, dm_rdata, want);
    end
    dm_read = 1'b0;
    n_tests++;
    if (grant_log.size() != 2) begin n_fail++; $display("FAIL rw_grant_count: got %0d want 2", grant_log.size()); end
  endtask

  task automatic test_reset_mid_read;
    logic [DW-1:0] want;
    int cyc, late;
    @(negedge clock);                           // T
    dm_read3 = 1'b1; dm_addr3 = 16'h0004;
    @(negedge clock);                           // T+1
    n_tests++;
    if (mem_en3 !== 1'b1) begin n_fail++; $display("FAIL mid_issue: got en=%b want 1", mem_en3); end
    @(negedge clock);                           // T+2 WAIT
    reset3 = 1'b0;
    @(negedge clock);                           // T+3
    n_tests++;
    if ({mem_en3, dm_ready3, u_dut3.state, dm_rdata3} !== {1'b0, 1'b0, 2'd0, 16'h0000}) begin
      n_fail++; $display("FAIL mid_reset: got en=%b ready=%b state=%0d data=%h want 0 0 0 0000", mem_en3, dm_ready3, u_dut3.state, dm_rdata3);
    end
    reset3 = 1'b1; dm_read3 = 1'b0;
    late = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (dm_ready3 || dm_rdata3 !== 16'h0000 || pipe_stall3) late++;
    end
    n_tests++;
    if (late != 0) begin n_fail++; $display("FAIL mid_no_pulse: got %0d bad cycles want 0", late); end
    dm_read3 = 1'b1; dm_addr3 = 16'h0004; exp_dm3.push_back(16'hA5C3);
    wait_dm3_ready(12, cyc);
    want = exp_dm3.pop_front();
    n_tests++;
    if ({dm_ready3, dm_rdata3} !== {1'b1, want} || cyc != 5) begin
      n_fail++; $display("FAIL lat3_read: got ready=%b data=%h after %0d want ready=1 data=%h after 5", dm_ready3, dm_rdata3, cyc, want);
    end
    dm_read3 = 1'b0;
  endtask

  initial begin
    reset = 1'b0; reset3 = 1'b0;
    if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 0; if_addr3 = '0; dm_read3 = 0; dm_write3 = 0; dm_addr3 = '0; dm_wdata3 = '0;
    preload(15'h0002, 16'hA5C3);
    preload(15'h0080, 16'hF00D);
    for (int i = 0; i < 6; i++) preload(15'h0100 + 15'(i), 16'h5000 + 16'(i));
    test_reset();
    test_fetch_read();
    test_write_priority();
    test_starvation();
    test_rw_conflict();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
